// File: rtl/link_arbiter.sv
// link_arbiter: round-robin arbiter granting one serial channel at a time to transmit or receive
//
// Parameters:
//   NCH      number of channels (1..16)
//   TIMEOUT  watchdog limit in cycles (2..65535), used only with LINK_ARBITER_TIMEOUT_EN
// Ports:
//   ref_clk      system clock
//   nreset       asynchronous active-low reset
//   tx_in        per-channel transmit request
//   rx_in        per-channel receive request
//   tx_done      per-channel transmit complete
//   rx_done      per-channel receive consumed
//   tx_out       transmit grant (one-hot or zero)
//   rx_out       receive request (one-hot or zero)
//   received     receive-complete acknowledge (one-hot or zero)
//   busy         high whenever not IDLE
//   active_ch    index of the channel being serviced, held while busy
//   timeout_err  one-cycle pulse on watchdog abort
// Configuration:
//   LINK_ARBITER_TIMEOUT_EN  builds the TRANSMIT/RECEIVE watchdog; otherwise timeout_err is constant 0
module link_arbiter #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                               ref_clk,
    input  logic                               nreset,
    input  logic [NCH-1:0]                     tx_in,
    input  logic [NCH-1:0]                     rx_in,
    input  logic [NCH-1:0]                     tx_done,
    input  logic [NCH-1:0]                     rx_done,
    output logic [NCH-1:0]                     tx_out,
    output logic [NCH-1:0]                     rx_out,
    output logic [NCH-1:0]                     received,
    output logic                               busy,
    output logic [$clog2(NCH > 1 ? NCH : 2)-1:0] active_ch,
    output logic                               timeout_err
);
    localparam int CW = $clog2(NCH > 1 ? NCH : 2);

    typedef enum logic [1:0] {IDLE, TRANSMIT, RECEIVE, WAITING} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [NCH-1:0] tx_out_q, tx_out_d;
    logic [NCH-1:0] rx_out_q, rx_out_d;
    logic [NCH-1:0] received_q, received_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [NCH-1:0] req;
    logic [CW-1:0]  cand, pick;
    logic           found;
    logic           timed_out;

`ifdef LINK_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] cnt_q, cnt_d;
    // cnt_q counts edges already spent in the state, so the compare fires on the TIMEOUT-th edge
    assign timed_out = (cnt_q == TW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign req = tx_in | rx_in;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        ch_d       = ch_q;
        tx_out_d   = tx_out_q;
        rx_out_d   = rx_out_q;
        received_d = received_q;
        err_d      = 1'b0;
        found      = 1'b0;
        pick       = '0;
        cand       = '0;
`ifdef LINK_ARBITER_TIMEOUT_EN
        cnt_d      = cnt_q + 1'b1;
`endif
        // Walk downward so the candidate closest to rr_ptr is the last one written
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = CW'((int'(rr_ptr_q) + i) % NCH);
            if (req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    ch_d     = pick;
                    rr_ptr_d = (pick == CW'(NCH - 1)) ? '0 : pick + 1'b1;
                    state_d  = tx_in[pick] ? TRANSMIT : RECEIVE;
                    tx_out_d = tx_in[pick] ? NCH'(1) << pick : '0;
                    rx_out_d = tx_in[pick] ? '0 : NCH'(1) << pick;
`ifdef LINK_ARBITER_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            TRANSMIT: begin
                if (tx_done[ch_q] || timed_out) begin
                    state_d  = IDLE;
                    tx_out_d = '0;
                    err_d    = !tx_done[ch_q];
                end
            end
            RECEIVE: begin
                if (rx_done[ch_q]) begin
                    state_d    = WAITING;
                    rx_out_d   = '0;
                    received_d = NCH'(1) << ch_q;
                end else if (timed_out) begin
                    state_d  = IDLE;
                    rx_out_d = '0;
                    err_d    = 1'b1;
                end
            end
            default: begin
                if (!rx_in[ch_q]) begin
                    state_d    = IDLE;
                    received_d = '0;
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ref_clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            ch_q       <= '0;
            tx_out_q   <= '0;
            rx_out_q   <= '0;
            received_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LINK_ARBITER_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            ch_q       <= ch_d;
            tx_out_q   <= tx_out_d;
            rx_out_q   <= rx_out_d;
            received_q <= received_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef LINK_ARBITER_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign tx_out      = tx_out_q;
    assign rx_out      = rx_out_q;
    assign received    = received_q;
    assign busy        = busy_q;
    assign active_ch   = ch_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: directed and randomized self-checking bench for link_arbiter (NCH=4, TIMEOUT=8)
module tb_link_arbiter;
    localparam int NCH     = 4;
    localparam int TIMEOUT = 8;
`ifdef LINK_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           ref_clk;
    logic           nreset;
    logic [NCH-1:0] tx_in, rx_in, tx_done, rx_done;
    logic [NCH-1:0] tx_out, rx_out, received;
    logic           busy;
    logic [1:0]     active_ch;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;

    link_arbiter #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .ref_clk(ref_clk), .nreset(nreset),
        .tx_in(tx_in), .rx_in(rx_in), .tx_done(tx_done), .rx_done(rx_done),
        .tx_out(tx_out), .rx_out(rx_out), .received(received),
        .busy(busy), .active_ch(active_ch), .timeout_err(timeout_err)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    // Transaction-level reference: which channel is owned and what it is doing
    // (0 none, 1 transmitting, 2 receiving, 3 acknowledging), plus the next search start.
    int m_kind, m_ch, m_ptr, m_edges, m_c;
    bit m_err, m_found;

    always @(posedge ref_clk or negedge nreset) begin
        if (!nreset) begin
            m_kind = 0; m_ch = 0; m_ptr = 0; m_edges = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_kind == 0) begin
                m_found = 0;
                for (int j = 0; j < NCH; j++) begin
                    m_c = (m_ptr + j) % NCH;
                    if (!m_found && (tx_in[m_c] || rx_in[m_c])) begin
                        m_found = 1;
                        m_ch = m_c;
                        m_kind = tx_in[m_c] ? 1 : 2;
                        m_ptr = (m_c + 1) % NCH;
                        m_edges = 0;
                    end
                end
            end else if (m_kind == 1 || m_kind == 2) begin
                m_edges = m_edges + 1;
                if (m_kind == 1 && tx_done[m_ch]) m_kind = 0;
                else if (m_kind == 2 && rx_done[m_ch]) m_kind = 3;
                else if (TMO_EN && m_edges == TIMEOUT) begin
                    m_kind = 0;
                    m_err = 1;
                end
            end else if (!rx_in[m_ch]) begin
                m_kind = 0;
            end
        end
    end

    task automatic tick();
        @(negedge ref_clk);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        tx_in = '0; rx_in = '0; tx_done = '0; rx_done = '0;
        repeat (2) tick();
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        tx_in = '0; rx_in = '0; tx_done = '0; rx_done = '0;
        repeat (2) tick();
        checks++;
        if ({tx_out, rx_out, received, busy, active_ch, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b, want all zero", {tx_out, rx_out, received, busy, active_ch, timeout_err});
        end
        nreset = 1'b1;
    endtask

    task automatic test_single_tx();
        do_reset();
        tx_in = 4'b0100;
        tick();
        checks++;
        if (tx_out !== 4'b0100 || active_ch !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_tx_grant: tx_out=%b ch=%0d busy=%b, want 0100 2 1", tx_out, active_ch, busy);
        end
        tx_in = '0;
        tx_done = 4'b0100;
        tick();
        tx_done = '0;
        checks++;
        if (tx_out !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_tx_done: tx_out=%b busy=%b, want 0000 0", tx_out, busy);
        end
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 3, 0, 3};
        logic [3:0] want;
        do_reset();
        tx_in = 4'b1001;
        for (int g = 0; g < 4; g++) begin
            want = 4'b0001 << order[g];
            tick();
            checks++;
            if (tx_out !== want || active_ch !== 2'(order[g])) begin
                errors++;
                $display("FAIL rr_grant_%0d: tx_out=%b ch=%0d, want %b %0d", g, tx_out, active_ch, want, order[g]);
            end
            tx_done = want;
            tick();
            tx_done = '0;
            checks++;
            if (busy !== 1'b0 || tx_out !== 4'b0000) begin
                errors++;
                $display("FAIL rr_idle_%0d: busy=%b tx_out=%b, want 0 0000", g, busy, tx_out);
            end
        end
        tx_in = '0;
    endtask

    task automatic test_receive();
        do_reset();
        rx_in = 4'b0010;
        tick();
        checks++;
        if (rx_out !== 4'b0010 || active_ch !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rx_grant: rx_out=%b ch=%0d busy=%b, want 0010 1 1", rx_out, active_ch, busy);
        end
        rx_done = 4'b0010;
        tick();
        rx_done = '0;
        checks++;
        if (received !== 4'b0010 || rx_out !== 4'b0000) begin
            errors++;
            $display("FAIL rx_done: received=%b rx_out=%b, want 0010 0000", received, rx_out);
        end
        tick();
        checks++;
        if (received !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rx_hold: received=%b busy=%b, want 0010 1", received, busy);
        end
        rx_in = '0;
        tick();
        checks++;
        if (received !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_release: received=%b busy=%b, want 0000 0", received, busy);
        end
    endtask

    task automatic test_tx_over_rx();
        do_reset();
        tx_in = 4'b0101;
        rx_in = 4'b0001;
        tick();
        checks++;
        if (tx_out !== 4'b0001 || rx_out !== 4'b0000) begin
            errors++;
            $display("FAIL pref_tx_first: tx_out=%b rx_out=%b, want 0001 0000", tx_out, rx_out);
        end
        tx_in = 4'b0100;
        tx_done = 4'b0001;
        tick();
        tx_done = '0;
        tick();
        checks++;
        if (tx_out !== 4'b0100 || rx_out !== 4'b0000 || active_ch !== 2'd2) begin
            errors++;
            $display("FAIL pref_ch2_before_wrap: tx_out=%b rx_out=%b ch=%0d, want 0100 0000 2", tx_out, rx_out, active_ch);
        end
        tx_in = '0;
        tx_done = 4'b0100;
        tick();
        tx_done = '0;
        tick();
        checks++;
        if (rx_out !== 4'b0001 || tx_out !== 4'b0000 || active_ch !== 2'd0) begin
            errors++;
            $display("FAIL pref_rx_after_wrap: rx_out=%b tx_out=%b ch=%0d, want 0001 0000 0", rx_out, tx_out, active_ch);
        end
        rx_done = 4'b0001;
        tick();
        rx_done = '0;
        rx_in = '0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        tx_in = 4'b1000;
        tick();
        tx_in = '0;
        for (int e = 1; e < TIMEOUT; e++) begin
            tick();
            checks++;
            if (tx_out !== 4'b1000 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait_%0d: tx_out=%b err=%b, want 1000 0", e, tx_out, timeout_err);
            end
        end
        tick();
        checks++;
        if (tx_out !== 4'b0000 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_expire: tx_out=%b err=%b busy=%b, want 0000 1 0", tx_out, timeout_err, busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse_width: err=%b, want 0", timeout_err);
        end
        tx_in = 4'b1000;
        tick();
        tx_in = '0;
        repeat (TIMEOUT - 1) tick();
        tx_done = 4'b1000;
        tick();
        tx_done = '0;
        checks++;
        if (tx_out !== 4'b0000 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_done_wins: tx_out=%b err=%b busy=%b, want 0000 0 0", tx_out, timeout_err, busy);
        end
    endtask

    task automatic test_reset_mid_receive();
        do_reset();
        rx_in = 4'b0100;
        tick();
        checks++;
        if (rx_out !== 4'b0100 || active_ch !== 2'd2) begin
            errors++;
            $display("FAIL midrst_setup: rx_out=%b ch=%0d, want 0100 2", rx_out, active_ch);
        end
        tx_in = 4'b0001;
        #2 nreset = 1'b0;
        #1;
        checks++;
        if ({tx_out, rx_out, received, busy, active_ch, timeout_err} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got %b, want all zero", {tx_out, rx_out, received, busy, active_ch, timeout_err});
        end
        tick();
        nreset = 1'b1;
        tick();
        checks++;
        if (tx_out !== 4'b0001 || rx_out !== 4'b0000 || active_ch !== 2'd0) begin
            errors++;
            $display("FAIL midrst_first_grant: tx_out=%b rx_out=%b ch=%0d, want 0001 0000 0", tx_out, rx_out, active_ch);
        end
        tx_in = '0;
        rx_in = '0;
        tx_done = 4'b0001;
        tick();
        tx_done = '0;
    endtask

    task automatic test_random();
        logic [3:0] e_tx, e_rx, e_rcv;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            e_tx  = (m_kind == 1) ? 4'(1 << m_ch) : 4'b0;
            e_rx  = (m_kind == 2) ? 4'(1 << m_ch) : 4'b0;
            e_rcv = (m_kind == 3) ? 4'(1 << m_ch) : 4'b0;
            checks++;
            if (tx_out !== e_tx || rx_out !== e_rx || received !== e_rcv || busy !== (m_kind != 0)
                || active_ch !== 2'(m_ch) || timeout_err !== m_err) begin
                errors++;
                $display("FAIL random_%0d: tx=%b rx=%b rcv=%b busy=%b ch=%0d err=%b, want %b %b %b %b %0d %b",
                         n, tx_out, rx_out, received, busy, active_ch, timeout_err,
                         e_tx, e_rx, e_rcv, m_kind != 0, m_ch, m_err);
            end
            tx_in   = 4'($urandom & $urandom);
            rx_in   = 4'($urandom | $urandom);
            tx_done = 4'($urandom & $urandom & $urandom);
            rx_done = 4'($urandom & $urandom & $urandom);
            tick();
        end
    endtask

    initial begin
        nreset = 1'b0;
        tx_in = '0; rx_in = '0; tx_done = '0; rx_done = '0;
        test_reset();
        test_single_tx();
        test_round_robin();
        test_receive();
        test_tx_over_rx();
        if (TMO_EN) test_timeout();
        test_reset_mid_receive();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
